mig_app_model: RTL and testbench

Synthesizable responder for the MIG 7-series user (app) interface, used in place of `mig_7series_0` so that `ddr_burst` and its burst initiators can be simulated and brought up without the DDR3 PHY. The block accepts app-interface write and read commands and stores write data in a small internal RAM. It returns read data in command order after a fixed latency, and emits `init_calib_complete` after a configurable delay. It sits directly on the `app_*` side of `ddr_burst`.

---
 rtl/mig_model_pkg.sv | 17 +
 rtl/mig_model_fifo.sv | 56 +++++
 rtl/mig_app_model.sv | 146 ++++++++++++++
 tb/tb_mig_app_model.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_model_pkg.sv
// Shared constants for the MIG 7-series app-interface responder model.
package mig_model_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int unsigned FIFO_DEPTH = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci feedback for x^16+x^14+x^13+x^11+1 (state bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mig_model_fifo.sv
// Small synchronous FIFO with registered occupancy; holds either app commands
// or write-data beats for the MIG model.
module mig_model_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push;
  logic             pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mig_app_model.sv
// MIG 7-series app-interface responder: RAM-backed, in-order, fixed read latency.
// Define MIG_MODEL_BACKPRESSURE_EN to add LFSR-driven ready stalls.
module mig_app_model
  import mig_model_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 28,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned MEM_AW       = 10,
  parameter int unsigned RD_LATENCY   = 8,
  parameter int unsigned CALIB_CYCLES = 64
) (
  input  logic                  ui_clk,
  input  logic                  ui_clk_sync_rst,
  output logic                  init_calib_complete,
  input  logic [ADDR_WIDTH-1:0] app_addr,
  input  logic [2:0]            app_cmd,
  input  logic                  app_en,
  output logic                  app_rdy,
  input  logic [DATA_WIDTH-1:0] app_wdf_data,
  input  logic                  app_wdf_wren,
  input  logic                  app_wdf_end,
  output logic                  app_wdf_rdy,
  output logic [DATA_WIDTH-1:0] app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rd_data_end
);

  localparam int unsigned CmdW     = 3 + MEM_AW;
  localparam int unsigned CalW     = $clog2(CALIB_CYCLES + 1);
  localparam int unsigned CntW     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned MemDepth = 1 << MEM_AW;

  // Calibration counter saturates at CALIB_CYCLES.
  logic [CalW-1:0] cal_cnt_q;
  logic            calib;

  assign calib = (cal_cnt_q == CalW'(CALIB_CYCLES));
  assign init_calib_complete = calib;

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) cal_cnt_q <= '0;
    else if (!calib)     cal_cnt_q <= cal_cnt_q + CalW'(1);
  end

  logic cmd_stall;
  logic wdf_stall;

`ifdef MIG_MODEL_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) lfsr_q <= LFSR_SEED;
    else                 lfsr_q <= lfsr_next(lfsr_q);
  end

  assign cmd_stall = (lfsr_q[1:0] == 2'b00);
  assign wdf_stall = (lfsr_q[3:2] == 2'b00);
`else
  assign cmd_stall = 1'b0;
  assign wdf_stall = 1'b0;
`endif

  logic                  cmd_full, cmd_empty, cmd_pop;
  logic                  wdf_full, wdf_empty, wdf_pop;
  logic [CmdW-1:0]       cmd_head;
  logic [DATA_WIDTH-1:0] wdf_head;
  logic [CntW-1:0]       cmd_count, wdf_count;

  assign app_rdy     = calib && !cmd_full && !cmd_stall;
  assign app_wdf_rdy = calib && !wdf_full && !wdf_stall;

  mig_model_fifo #(
    .Width (CmdW),
    .Depth (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (ui_clk),
    .rst_i   (ui_clk_sync_rst),
    .push_i  (app_en && app_rdy),
    .data_i  ({app_cmd, app_addr[MEM_AW+2:3]}),
    .pop_i   (cmd_pop),
    .data_o  (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .count_o (cmd_count)
  );

  mig_model_fifo #(
    .Width (DATA_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_wdf_fifo (
    .clk_i   (ui_clk),
    .rst_i   (ui_clk_sync_rst),
    .push_i  (app_wdf_wren && app_wdf_rdy),
    .data_i  (app_wdf_data),
    .pop_i   (wdf_pop),
    .data_o  (wdf_head),
    .full_o  (wdf_full),
    .empty_o (wdf_empty),
    .count_o (wdf_count)
  );

  logic [2:0]        head_cmd;
  logic [MEM_AW-1:0] head_idx;
  logic              do_write, do_read, do_drop;

  assign head_cmd = cmd_head[CmdW-1:MEM_AW];
  assign head_idx = cmd_head[MEM_AW-1:0];

  // A write at the head waits for its data and blocks everything behind it.
  always_comb begin
    do_write = !cmd_empty && (head_cmd == CMD_WRITE) && !wdf_empty;
    do_read  = !cmd_empty && (head_cmd == CMD_READ);
    do_drop  = !cmd_empty && (head_cmd != CMD_WRITE) && (head_cmd != CMD_READ);
    cmd_pop  = do_write || do_read || do_drop;
    wdf_pop  = do_write;
  end

  logic [DATA_WIDTH-1:0] ram_q [MemDepth];

  always_ff @(posedge ui_clk) begin
    if (do_write) ram_q[head_idx] <= wdf_head;
  end

  // Stage 0 is the synchronous RAM read; stages 1..RD_LATENCY-1 form the delay line.
  logic [RD_LATENCY-1:0] rd_vld_q;
  logic [DATA_WIDTH-1:0] rd_dat_q [RD_LATENCY];

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      rd_vld_q <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) rd_dat_q[i] <= '0;
    end else begin
      rd_vld_q    <= {rd_vld_q[RD_LATENCY-2:0], do_read};
      rd_dat_q[0] <= ram_q[head_idx];
      for (int i = 1; i < int'(RD_LATENCY); i++) rd_dat_q[i] <= rd_dat_q[i-1];
    end
  end

  assign app_rd_data       = rd_dat_q[RD_LATENCY-1];
  assign app_rd_data_valid = rd_vld_q[RD_LATENCY-1];
  assign app_rd_data_end   = rd_vld_q[RD_LATENCY-1];

  logic unused_inputs;
  assign unused_inputs = ^{app_wdf_end, app_addr, cmd_count, wdf_count};

endmodule

// File: tb/tb_mig_app_model.sv
// Randomized and directed bench for mig_app_model against an in-order memory model.
module tb_mig_app_model;

  localparam int unsigned AW  = 28;
  localparam int unsigned DW  = 128;
  localparam int unsigned MAW = 10;
  localparam int unsigned RDL = 8;
  localparam int unsigned CAL = 64;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  logic          ui_clk = 1'b0;
  logic          ui_clk_sync_rst = 1'b1;
  logic          init_calib_complete;
  logic [AW-1:0] app_addr = '0;
  logic [2:0]    app_cmd = '0;
  logic          app_en = 1'b0;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data = '0;
  logic          app_wdf_wren = 1'b0;
  logic          app_wdf_end = 1'b1;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;

  always #5 ui_clk = ~ui_clk;

  mig_app_model #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .MEM_AW       (MAW),
    .RD_LATENCY   (RDL),
    .CALIB_CYCLES (CAL)
  ) dut (
    .ui_clk              (ui_clk),
    .ui_clk_sync_rst     (ui_clk_sync_rst),
    .init_calib_complete (init_calib_complete),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end)
  );

  // Reference model: commands applied in order, writes paired with data beats in order.
  typedef struct {
    logic [2:0] cmd;
    int         idx;
  } mcmd_t;

  mcmd_t         pend_cmd[$];
  logic [DW-1:0] pend_dat[$];
  logic [DW-1:0] exp_q[$];
  bit            known_q[$];
  logic [DW-1:0] mem_m [int];
  logic [DW-1:0] pre_data [16];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit last_cmd_acc;
  bit last_wdf_acc;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int word_idx(input logic [AW-1:0] a);
    return (int'(a) / 8) % (1 << MAW);
  endfunction

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void drain();
    while (pend_cmd.size() > 0) begin
      if (pend_cmd[0].cmd == CMD_WR) begin
        if (pend_dat.size() == 0) break;
        mem_m[pend_cmd[0].idx] = pend_dat.pop_front();
      end else if (pend_cmd[0].cmd == CMD_RD) begin
        known_q.push_back(mem_m.exists(pend_cmd[0].idx));
        exp_q.push_back(mem_m.exists(pend_cmd[0].idx) ? mem_m[pend_cmd[0].idx] : '0);
      end
      void'(pend_cmd.pop_front());
    end
  endfunction

  // One clock: score outputs, record handshakes into the model, advance.
  task automatic cycle();
    mcmd_t c;
    if (app_rd_data_valid === 1'b1 || app_rd_data_end === 1'b1)
      check("rd_end", DW'(app_rd_data_end), DW'(app_rd_data_valid));
    if (app_rd_data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        logic [DW-1:0] e;
        bit k;
        e = exp_q.pop_front();
        k = known_q.pop_front();
        if (k) check("rd_data", app_rd_data, e);
      end
    end
    last_cmd_acc = app_en && app_rdy;
    last_wdf_acc = app_wdf_wren && app_wdf_rdy;
    if (ui_clk_sync_rst) begin
      pend_cmd.delete();
      pend_dat.delete();
      exp_q.delete();
      known_q.delete();
    end else begin
      if (last_cmd_acc) begin
        c.cmd = app_cmd;
        c.idx = word_idx(app_addr);
        pend_cmd.push_back(c);
      end
      if (last_wdf_acc) pend_dat.push_back(app_wdf_data);
      drain();
    end
    @(posedge ui_clk);
    #1;
    cyc++;
  endtask

  task automatic send(input bit do_cmd, input logic [2:0] cmd, input logic [AW-1:0] addr,
                      input bit do_dat, input logic [DW-1:0] data);
    bit c_done;
    bit d_done;
    c_done = !do_cmd;
    d_done = !do_dat;
    app_cmd = cmd;
    app_addr = addr;
    app_wdf_data = data;
    for (int i = 0; i < 50 && !(c_done && d_done); i++) begin
      app_en = !c_done;
      app_wdf_wren = !d_done;
      cycle();
      if (last_cmd_acc) c_done = 1'b1;
      if (last_wdf_acc) d_done = 1'b1;
    end
    app_en = 1'b0;
    app_wdf_wren = 1'b0;
    if (!(c_done && d_done)) check("send_timeout", 0, 1);
  endtask

  task automatic wait_valid(input string tag, output logic [DW-1:0] d, output int at);
    for (int i = 0; i < 40 && app_rd_data_valid !== 1'b1; i++) cycle();
    if (app_rd_data_valid !== 1'b1) check({tag, "_timeout"}, 0, 1);
    d = app_rd_data;
    at = cyc;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] v;
    int t0, vt, cnt, idx, r;

    // Reset state and calibration.
    repeat (3) cycle();
    ui_clk_sync_rst = 1'b0;
    check("rst_calib", DW'(init_calib_complete), 0);
    check("rst_rdy", DW'(app_rdy), 0);
    check("rst_wdf_rdy", DW'(app_wdf_rdy), 0);
    check("rst_valid", DW'(app_rd_data_valid), 0);
    check("rst_end", DW'(app_rd_data_end), 0);
    check("rst_data", app_rd_data, 0);
    app_en = 1'b1;
    app_cmd = CMD_RD;
    app_wdf_wren = 1'b1;
    cnt = 0;
    for (int i = 0; i < int'(CAL); i++) begin
      if (app_rdy || app_wdf_rdy || init_calib_complete) cnt++;
      cycle();
    end
    check("calib_early", cnt, 0);
    check("calib_done", DW'(init_calib_complete), 1);
    check("calib_rdy", DW'(app_rdy), 1);
    app_en = 1'b0;
    app_wdf_wren = 1'b0;

    for (int i = 0; i < 16; i++) begin
      pre_data[i] = rnd();
      send(1'b1, CMD_WR, AW'(i * 8), 1'b1, pre_data[i]);
    end
    repeat (3) cycle();

    // Single write then read: exact latency.
    app_en = 1'b1;
    app_cmd = CMD_WR;
    app_addr = AW'('h40);
    app_wdf_wren = 1'b1;
    app_wdf_data = DW'(128'hDEAD_BEEF);
    t0 = cyc;
    check("t2_wr_acc", DW'(app_rdy && app_wdf_rdy), 1);
    cycle();
    app_cmd = CMD_RD;
    app_wdf_wren = 1'b0;
    check("t2_rd_acc", DW'(app_rdy), 1);
    cycle();
    app_en = 1'b0;
    wait_valid("t2", d, vt);
    check("t2_latency", DW'(vt - t0), DW'(RDL + 2));
    check("t2_data", d, DW'(128'hDEAD_BEEF));
    check("t2_end", DW'(app_rd_data_end), 1);
    cycle();
    check("t2_one_cycle", DW'(app_rd_data_valid), 0);

    // Data ahead of its command; the intervening read must not overtake the write.
    v = rnd();
    app_wdf_data = v;
    app_wdf_wren = 1'b1;
    check("t3_wdf_rdy", DW'(app_wdf_rdy), 1);
    cycle();
    app_wdf_wren = 1'b0;
    cycle();
    cycle();
    app_en = 1'b1;
    app_cmd = CMD_WR;
    app_addr = AW'('h8);
    check("t3_wr_acc", DW'(app_rdy), 1);
    cycle();
    app_cmd = CMD_RD;
    app_addr = AW'('h10);
    check("t3_rd1_acc", DW'(app_rdy), 1);
    cycle();
    app_addr = AW'('h8);
    check("t3_rd2_acc", DW'(app_rdy), 1);
    cycle();
    app_en = 1'b0;
    wait_valid("t3_a", d, vt);
    check("t3_first", d, pre_data[2]);
    cycle();
    wait_valid("t3_b", d, vt);
    check("t3_second", d, v);
    cycle();
    repeat (3) cycle();

    // Command FIFO backpressure: writes without data.
    app_en = 1'b1;
    app_cmd = CMD_WR;
    for (int i = 0; i < 4; i++) begin
      app_addr = AW'((3 + i) * 8);
      check("t4_rdy", DW'(app_rdy), 1);
      cycle();
    end
    check("t4_full", DW'(app_rdy), 0);
    app_addr = AW'(7 * 8);
    app_wdf_data = rnd();
    app_wdf_wren = 1'b1;
    check("t4_wdf_rdy", DW'(app_wdf_rdy), 1);
    cycle();
    app_wdf_wren = 1'b0;
    check("t4_still_full", DW'(app_rdy), 0);
    cycle();
    check("t4_rdy_back", DW'(app_rdy), 1);
    cycle();
    app_en = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, CMD_WR, '0, 1'b1, rnd());
    repeat (3) cycle();

    // Aliased streaming reads of index 0.
    v = rnd();
    send(1'b1, CMD_WR, '0, 1'b1, v);
    app_en = 1'b1;
    app_cmd = CMD_RD;
    app_addr = AW'(1) << (MAW + 3);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_cmd_acc) cnt++;
    end
    app_en = 1'b0;
    check("t5_accepts", cnt, 8);
    wait_valid("t5", d, vt);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (app_rd_data_valid === 1'b1 && app_rd_data === v) cnt++;
      cycle();
    end
    check("t5_stream", cnt, 8);
    check("t5_after", DW'(app_rd_data_valid), 0);

    // Randomized traffic over indices 0..15 with aliasing and illegal commands.
    for (int i = 0; i < 400; i++) begin
      idx = $urandom_range(0, 15);
      r = $urandom_range(0, 99);
      app_en = 1'($urandom_range(0, 1));
      app_cmd = (r < 45) ? CMD_WR : (r < 90) ? CMD_RD : 3'($urandom_range(2, 7));
      app_addr = AW'(($urandom & 32'h0FFF_E000) | (idx * 8) | $urandom_range(0, 7));
      app_wdf_wren = 1'($urandom_range(0, 1));
      app_wdf_data = rnd();
      cycle();
    end
    app_en = 1'b0;
    for (int i = 0; i < 100 && pend_cmd.size() > 0; i++) begin
      app_wdf_wren = 1'b1;
      app_wdf_data = rnd();
      cycle();
    end
    app_wdf_wren = 1'b0;
    check("rand_cmd_flush", pend_cmd.size(), 0);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle();
    check("rand_drain", exp_q.size(), 0);

    // Reset with reads in flight; RAM contents must survive.
    app_en = 1'b1;
    app_cmd = CMD_RD;
    for (int i = 0; i < 4; i++) begin
      app_addr = AW'(i * 8);
      check("t6_acc", DW'(app_rdy), 1);
      cycle();
    end
    app_en = 1'b0;
    ui_clk_sync_rst = 1'b1;
    cycle();
    ui_clk_sync_rst = 1'b0;
    check("t6_rst_valid", DW'(app_rd_data_valid), 0);
    check("t6_rst_rdy", DW'(app_rdy), 0);
    check("t6_rst_calib", DW'(init_calib_complete), 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (app_rd_data_valid === 1'b1) cnt++;
      cycle();
    end
    check("t6_no_valid", cnt, 0);
    for (int i = 0; i < 100 && !init_calib_complete; i++) cycle();
    check("t6_recal", DW'(init_calib_complete), 1);
    for (int i = 0; i < 16; i++) send(1'b1, CMD_RD, AW'(i * 8), 1'b0, '0);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle();
    check("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
